// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver; data_in/en in, majority-voted word out on data_out with valid/ready handshake and parity/frame/overrun, start/busy/done status
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 rx_clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 data_in,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 start,
  output logic                 busy,
  output logic                 done
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] V0   = CW'(M - 1);
  localparam logic [CW-1:0] V1   = CW'(M);
  localparam logic [CW-1:0] V2   = CW'(M + 1);
  localparam logic [CW-1:0] CMAX = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
  localparam logic          ODD   = 1'(PARITY_ODD);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic s1, s2, prev;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [1:0] smp;
  logic [DATA_BITS-1:0] sh;
  logic perr_acc, ferr_acc;
  logic fall, at_vote, vote, last_bit, complete;
  always_ff @(posedge rx_clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1 <= data_in;
      s2 <= s1;
      if (en) prev <= s2;
    end
  assign fall     = prev & ~s2;
  assign at_vote  = en && cnt == V2;
  assign vote     = (smp[0] & smp[1]) | (smp[0] & s2) | (smp[1] & s2);
  assign last_bit = bcnt == BLAST;
  assign complete = at_vote && state == STOP && bcnt == SLAST;
  always_ff @(posedge rx_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = en && fall ? START : IDLE;
      START:   state_n = at_vote ? (vote ? IDLE : DATA) : START;
      DATA:    state_n = at_vote && last_bit ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_n = at_vote ? STOP : PARITY;
      STOP:    state_n = complete ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    start = state == START;
    busy  = state == DATA || state == PARITY || state == STOP;
  end
  always_ff @(posedge rx_clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      bcnt     <= '0;
      smp      <= '0;
      sh       <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (en) begin
      if (state == IDLE) begin
        cnt      <= '0;
        bcnt     <= '0;
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end else begin
        cnt <= cnt == CMAX ? '0 : cnt + 1'b1;
        if (cnt == V0) smp[0] <= s2;
        if (cnt == V1) smp[1] <= s2;
        if (at_vote && state == DATA) begin
          sh   <= {vote, sh[DATA_BITS-1:1]};
          bcnt <= last_bit ? '0 : bcnt + 1'b1;
        end
        if (at_vote && state == PARITY) perr_acc <= ((^sh) ^ vote) != ODD;
        if (at_vote && state == STOP) begin
          ferr_acc <= ferr_acc | ~vote;
          bcnt     <= bcnt + 1'b1;
        end
      end
    end
  always_ff @(posedge rx_clk or negedge rst_n)
    if (!rst_n) begin
      data_out    <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= complete;
      overrun_err <= complete && valid && !ready;
      if (complete && (!valid || ready)) begin
        data_out   <= sh;
        parity_err <= perr_acc;
        frame_err  <= ferr_acc | ~vote;
        valid      <= 1'b1;
      end else if (valid && ready) valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized frame-level scoreboard bench for three uart_rx_param configurations
module tb_uart_rx_param;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [2:0] line = '1, rdy = '1;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic [2:0] vld, pe, fe, ov, st, bs, dn;
  logic [12:0] got_q[$], exp_q[$];
  int n_chk = 0, n_err = 0;
  int dn_cnt[3] = '{0, 0, 0}, ov_cnt[3] = '{0, 0, 0}, st_cyc[3] = '{0, 0, 0}, bs_cyc[3] = '{0, 0, 0};
  int exp_done[3] = '{0, 0, 0};
  always #5 clk = ~clk;
  uart_rx_param u0 (
    .rx_clk(clk), .rst_n(rst_n), .en(en), .data_in(line[0]), .ready(rdy[0]),
    .data_out(d0), .valid(vld[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun_err(ov[0]), .start(st[0]), .busy(bs[0]), .done(dn[0])
  );
  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .rx_clk(clk), .rst_n(rst_n), .en(en), .data_in(line[1]), .ready(rdy[1]),
    .data_out(d1), .valid(vld[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun_err(ov[1]), .start(st[1]), .busy(bs[1]), .done(dn[1])
  );
  uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(10), .STOP_BITS(2)) u2 (
    .rx_clk(clk), .rst_n(rst_n), .en(en), .data_in(line[2]), .ready(rdy[2]),
    .data_out(d2), .valid(vld[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun_err(ov[2]), .start(st[2]), .busy(bs[2]), .done(dn[2])
  );
  function automatic int os_of(int i); return i == 2 ? 10 : 16; endfunction
  function automatic int db_of(int i); return i == 2 ? 5 : 8; endfunction
  function automatic int pe_of(int i); return i == 1 ? 1 : 0; endfunction
  function automatic int sb_of(int i); return i == 2 ? 2 : 1; endfunction
  function automatic int nb(int i); return 1 + db_of(i) + pe_of(i) + sb_of(i); endfunction
  function automatic logic [8:0] dat(int i);
    return i == 0 ? {1'b0, d0} : i == 1 ? {1'b0, d1} : {4'b0, d2};
  endfunction
  function automatic logic [15:0] outs(int i);
    return {dat(i), vld[i], pe[i], fe[i], ov[i], st[i], bs[i], dn[i]};
  endfunction
  function automatic logic [15:0] frame(int i, logic [8:0] d, logic pb, logic [1:0] sp);
    logic [15:0] b;
    int n;
    b = '1;
    b[0] = 1'b0;
    for (int j = 0; j < db_of(i); j++) b[1 + j] = d[j];
    n = 1 + db_of(i);
    if (pe_of(i) != 0) begin b[n] = pb; n++; end
    b[n] = sp[0];
    if (sb_of(i) == 2) b[n + 1] = sp[1];
    return b;
  endfunction
  function automatic logic [12:0] model(int i, logic [8:0] d, logic pb, logic [1:0] sp);
    logic [8:0] dm;
    logic p, f;
    dm = d & 9'((1 << db_of(i)) - 1);
    p = pe_of(i) != 0 && ((($countones(dm) + int'(pb)) % 2) != 0);
    f = !sp[0] || (sb_of(i) == 2 && !sp[1]);
    return {2'(i), f, p, dm};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int i, input int n);
    repeat (n) begin @(negedge clk); line[i] = 1'b1; end
  endtask
  task automatic drive(input int i, input logic [15:0] b, input int n, input bit gl);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < os_of(i); c++) begin
        @(negedge clk);
        line[i] = (gl && k >= 1 && k <= db_of(i) && c == os_of(i) / 2 + 1) ? ~b[k] : b[k];
      end
  endtask
  task automatic send(input int i, input logic [8:0] d, input logic pb, input logic [1:0] sp, input bit gl, input bit take);
    if (take) exp_q.push_back(model(i, d, pb, sp));
    exp_done[i]++;
    drive(i, frame(i, d, pb, sp), nb(i), gl);
    idle(i, 2 * os_of(i));
  endtask
  task automatic score(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && rdy[i]) got_q.push_back({2'(i), fe[i], pe[i], dat(i)});
      dn_cnt[i] += int'(dn[i]);
      ov_cnt[i] += int'(ov[i]);
      st_cyc[i] += int'(st[i]);
      bs_cyc[i] += int'(bs[i]);
    end
  end
  initial begin
    int s0, b0, dd;
    logic [8:0] d;
    logic [1:0] sp;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_outs", outs(i), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(0, 9'hA5, 1'b0, 2'b11, 1'b0, 1'b1);
    score("a5");
    chk("a5_overrun", ov_cnt[0], 0);
    send(1, 9'h3C, 1'b1, 2'b11, 1'b0, 1'b1);
    send(1, 9'h3C, 1'b0, 2'b11, 1'b0, 1'b1);
    score("parity");
    exp_q.push_back(model(0, 9'h5A, 1'b0, 2'b00));
    exp_done[0]++;
    s0 = st_cyc[0];
    drive(0, frame(0, 9'h5A, 1'b0, 2'b00), nb(0), 1'b0);
    s0 = st_cyc[0];
    repeat (32) @(negedge clk);
    chk("break_nostart", st_cyc[0] - s0, 0);
    idle(0, 32);
    score("frame_err");
    s0 = st_cyc[0];
    b0 = bs_cyc[0];
    dd = dn_cnt[0];
    repeat (4) begin @(negedge clk); line[0] = 1'b0; end
    idle(0, 48);
    chk("glitch_start", st_cyc[0] != s0, 1);
    chk("glitch_busy", bs_cyc[0] - b0, 0);
    chk("glitch_done", dn_cnt[0] - dd, 0);
    chk("glitch_valid", vld[0], 0);
    send(0, 9'h81, 1'b0, 2'b11, 1'b1, 1'b1);
    score("majority");
    rdy[0] = 1'b0;
    send(0, 9'h11, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("ovr_first", {vld[0], d0}, {1'b1, 8'h11});
    send(0, 9'h22, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("ovr_pulse", ov_cnt[0], 1);
    chk("ovr_keep", {vld[0], d0}, {1'b1, 8'h11});
    exp_q.push_back(model(0, 9'h11, 1'b0, 2'b11));
    exp_q.push_back(model(0, 9'h33, 1'b0, 2'b11));
    exp_done[0]++;
    fork
      drive(0, frame(0, 9'h33, 1'b0, 2'b11), nb(0), 1'b0);
      begin
        repeat ((nb(0) - 1) * 16 + 8 + 5) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        chk("ovr_third", {vld[0], d0}, {1'b1, 8'h33});
        chk("ovr_third_ovr", ov[0], 0);
        chk("ovr_third_done", dn[0], 1);
      end
    join
    idle(0, 32);
    rdy[0] = 1'b1;
    idle(0, 8);
    score("overrun");
    chk("ovr_total", ov_cnt[0], 1);
    send(2, 9'h15, 1'b0, 2'b01, 1'b0, 1'b1);
    score("d5s2");
    drive(2, frame(2, 9'h1B, 1'b0, 2'b11), 4, 1'b0);
    chk("mid_busy", bs[2], 1);
    dd = dn_cnt[2];
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", outs(2), 0);
    line[2] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2, 30);
    chk("mid_reset_nodone", dn_cnt[2] - dd, 0);
    send(2, 9'h0A, 1'b0, 2'b11, 1'b0, 1'b1);
    score("after_reset");
    for (int r = 0; r < 10; r++)
      for (int i = 0; i < 3; i++) begin
        d = 9'($urandom);
        sp = $urandom_range(0, 3) == 0 ? 2'($urandom_range(0, 2)) : 2'b11;
        send(i, d, 1'($urandom), sp, $urandom_range(0, 3) == 0, 1'b1);
      end
    score("random");
    for (int i = 0; i < 3; i++) chk("done_count", dn_cnt[i], exp_done[i]);
    chk("ovr_u1", ov_cnt[1], 0);
    chk("ovr_u2", ov_cnt[2], 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
